// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note codes, record format, recorder states and key encoder
package piano_pkg;

  localparam logic [3:0] NOTE_REST    = 4'd0;
  localparam logic [3:0] NOTE_DO      = 4'd1;
  localparam logic [3:0] NOTE_RE      = 4'd2;
  localparam logic [3:0] NOTE_MI      = 4'd3;
  localparam logic [3:0] NOTE_FA      = 4'd4;
  localparam logic [3:0] NOTE_SOL     = 4'd5;
  localparam logic [3:0] NOTE_LA      = 4'd6;
  localparam logic [3:0] NOTE_SI      = 4'd7;
  localparam logic [3:0] NOTE_DO_HIGH = 4'd8;

  localparam logic [3:0] DUR_MAX = 4'd15;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] dur;
  } note_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_REC
  } rec_state_t;

  // key[7] is do (code 1) ... key[0] is do_high (code 8); the MSB wins when several are pressed
  function automatic logic [3:0] encode_key(input logic [7:0] k);
    logic [3:0] c;
    c = NOTE_REST;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) c = 4'(8 - i);
    end
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - accepts an 8-bit key vector once it has held steady for DEB_CYCLES
module key_debounce #(
  parameter int DEB_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  output logic [7:0] stable_key
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [7:0]    last_key;
  logic [CW-1:0] cnt;

  // any change restarts the stability count; a full count promotes the vector
  always_ff @(posedge clk) begin
    if (rst) begin
      last_key   <= '0;
      cnt        <= '0;
      stable_key <= '0;
    end else if (key != last_key) begin
      last_key <= key;
      cnt      <= '0;
    end else if (cnt != CW'(DEB_CYCLES - 1)) begin
      cnt <= cnt + CW'(1);
    end else begin
      stable_key <= last_key;
    end
  end

endmodule

// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - records debounced key presses as note records and replays them as a stream
module note_recorder
  import piano_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int UNIT_CYCLES = 1600000,
  parameter int DEB_CYCLES  = 200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             key,
  input  logic                   rec_start,
  input  logic                   rec_stop,
  input  logic                   play_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] length,
  output logic                   recording,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int UW = $clog2(UNIT_CYCLES + 1);

  logic [7:0]    stable_key;
  logic [3:0]    stable_code;
  rec_state_t    state, state_n;
  logic [3:0]    cur_code, cur_code_n;
  logic [3:0]    dur, dur_n;
  logic [UW-1:0] unit_cnt;
  logic          unit_tick;
  logic          unit_rst;
  logic          clear;
  logic          wr_en;
  note_rec_t     wr_rec;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic          streaming;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .stable_key (stable_key)
  );

  assign stable_code = encode_key(stable_key);
  assign unit_tick   = (unit_cnt == UW'(UNIT_CYCLES - 1));
  assign recording   = (state != ST_IDLE);
  assign full        = (length == LW'(DEPTH));

  // free-running duration unit timer, re-phased when the first note starts
  always_ff @(posedge clk) begin
    if (rst || unit_rst || unit_tick) unit_cnt <= '0;
    else                              unit_cnt <= unit_cnt + UW'(1);
  end

  // recorder state and the note currently being timed
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_code <= NOTE_REST;
      dur      <= '0;
    end else begin
      state    <= state_n;
      cur_code <= cur_code_n;
      dur      <= dur_n;
    end
  end

  // next state, note timing and write decision
  always_comb begin
    state_n    = state;
    cur_code_n = cur_code;
    dur_n      = dur;
    wr_en      = 1'b0;
    wr_rec     = '0;
    clear      = 1'b0;
    unit_rst   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rec_start) begin
          clear   = 1'b1;
          state_n = ST_ARM;
        end
      end
      ST_ARM: begin
        if (rec_start) begin
          clear = 1'b1;
        end else if (rec_stop) begin
          state_n = ST_IDLE;
        end else if (stable_code != NOTE_REST) begin
          cur_code_n = stable_code;
          dur_n      = '0;
          unit_rst   = 1'b1;
          state_n    = ST_REC;
        end
      end
      ST_REC: begin
        if (rec_start) begin
          clear   = 1'b1;
          state_n = ST_ARM;
        end else begin
          if (stable_code != cur_code) begin
            if (dur != '0) begin
              wr_en       = 1'b1;
              wr_rec.code = cur_code;
              wr_rec.dur  = dur;
            end
            cur_code_n = stable_code;
            dur_n      = '0;
          end else if (unit_tick) begin
            if (dur == DUR_MAX - 4'd1) begin
              wr_en       = 1'b1;
              wr_rec.code = cur_code;
              wr_rec.dur  = DUR_MAX;
              dur_n       = '0;
            end else begin
              dur_n = dur + 4'd1;
            end
          end
          // a pending change/split record already covers this note, so no flush then
          if (rec_stop) begin
            if (!wr_en && cur_code != NOTE_REST && dur != '0) begin
              wr_en       = 1'b1;
              wr_rec.code = cur_code;
              wr_rec.dur  = dur;
            end
            state_n = ST_IDLE;
          end
          if (wr_en && length == LW'(DEPTH - 1)) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // stored record count, which also serves as the write pointer
  always_ff @(posedge clk) begin
    if (rst || clear) length <= '0;
    else if (wr_en)   length <= length + LW'(1);
  end

  // record buffer write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[length[AW-1:0]] <= wr_rec;
  end

  // playback: the output register is the synchronous RAM read, refilled whenever it empties or is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      streaming <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      rd_ptr    <= '0;
    end else if (rec_start) begin
      streaming <= 1'b0;
      out_valid <= 1'b0;
    end else if (play_start && !recording && length != '0) begin
      streaming <= 1'b1;
      out_valid <= 1'b0;
      rd_ptr    <= '0;
    end else if (streaming) begin
      if (out_valid && out_ready && out_last) begin
        streaming <= 1'b0;
        out_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
        out_data  <= mem[rd_ptr];
        out_last  <= (LW'(rd_ptr) == length - LW'(1));
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - directed scoreboard bench for note_recorder
module tb_note_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic       rec_start, rec_stop, play_start;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic [2:0] length;
  logic       recording, full;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  note_recorder #(.DEPTH(4), .UNIT_CYCLES(4), .DEB_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .rec_start  (rec_start),
    .rec_stop   (rec_stop),
    .play_start (play_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .length     (length),
    .recording  (recording),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    key = k;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rec_start();
    rec_start = 1'b1;
    @(negedge clk);
    rec_start = 1'b0;
  endtask

  task automatic pulse_rec_stop();
    rec_stop = 1'b1;
    @(negedge clk);
    rec_stop = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    logic [7:0] e;
    budget = 100;
    out_ready  = 1'b1;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        check({tag, "_data"}, 32'(out_data), 32'(e));
        check({tag, "_last"}, 32'(out_last), 32'(exp_q.size() == 0));
      end
      budget--;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_end"}, 32'(out_valid), 32'd0);
    exp_q.delete();
  endtask

  task automatic stream_toggle(input string tag, input int pops);
    int  budget;
    bit  r;
    budget = 200;
    r = 1'b1;
    while (pops > 0 && budget > 0) begin
      out_ready = r;
      r = !r;
      if (out_valid) begin
        check({tag, "_data"}, 32'(out_data), 32'(exp_q[0]));
        check({tag, "_last"}, 32'(out_last), 32'(exp_q.size() == 1));
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops--;
        end
      end
      budget--;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 32'(pops), 32'd0);
  endtask

  initial begin
    rst = 1'b1; key = 8'h00; rec_start = 1'b0; rec_stop = 1'b0;
    play_start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_recording", 32'(recording), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    hold(8'h00, 5);

    // long note split at 15 units, then remainder; trailing rest dropped
    pulse_rec_start();
    check("arm_recording", 32'(recording), 32'd1);
    exp_q.push_back(8'h1F); exp_q.push_back(8'h15);
    hold(8'h80, 82);
    hold(8'h00, 10);
    pulse_rec_stop();
    check("long_length", 32'(length), 32'd2);
    check("long_recording", 32'(recording), 32'd0);
    drain("long");

    // leading rest skipped, interior rest recorded, final note flushed on stop
    pulse_rec_start();
    exp_q.push_back(8'h33); exp_q.push_back(8'h02); exp_q.push_back(8'h84);
    hold(8'h00, 20);
    hold(8'h20, 14);
    hold(8'h00, 8);
    hold(8'h01, 19);
    pulse_rec_stop();
    hold(8'h00, 10);
    check("seq_length", 32'(length), 32'd3);
    drain("seq");

    // handshake playback with out_ready toggling 1010
    exp_q.push_back(8'h33); exp_q.push_back(8'h02); exp_q.push_back(8'h84);
    out_ready  = 1'b0;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    check("pb_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("pb_lat2", 32'(out_valid), 32'd1);
    stream_toggle("pb", 3);
    check("pb_end", 32'(out_valid), 32'd0);

    // play_start mid-stream rewinds to record 0
    exp_q.push_back(8'h33); exp_q.push_back(8'h02); exp_q.push_back(8'h84);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    stream_toggle("rs1", 1);
    out_ready  = 1'b0;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    check("rs_clear", 32'(out_valid), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h33); exp_q.push_back(8'h02); exp_q.push_back(8'h84);
    stream_toggle("rs2", 3);
    check("rs_end", 32'(out_valid), 32'd0);

    // two keys at once resolve to the higher (MSB) key
    pulse_rec_start();
    exp_q.push_back(8'h12);
    hold(8'hC0, 13);
    pulse_rec_stop();
    hold(8'h00, 10);
    check("chord_length", 32'(length), 32'd1);
    drain("chord");

    // one-cycle glitch does not split the held note
    pulse_rec_start();
    exp_q.push_back(8'h16);
    hold(8'h80, 10);
    hold(8'h40, 1);
    hold(8'h80, 18);
    pulse_rec_stop();
    hold(8'h00, 10);
    check("glitch_length", 32'(length), 32'd1);
    drain("glitch");

    // filling the buffer ends recording; later changes are discarded
    pulse_rec_start();
    exp_q.push_back(8'h12); exp_q.push_back(8'h22);
    exp_q.push_back(8'h32); exp_q.push_back(8'h42);
    hold(8'h80, 10);
    hold(8'h40, 8);
    hold(8'h20, 8);
    hold(8'h10, 8);
    hold(8'h08, 8);
    check("fill_length", 32'(length), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_idle", 32'(recording), 32'd0);
    hold(8'h04, 8);
    check("fill_length_after", 32'(length), 32'd4);
    hold(8'h00, 10);
    drain("fill");

    // reset mid-stream, then play_start with an empty buffer is ignored
    out_ready  = 1'b0;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    @(negedge clk);
    check("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_length", 32'(length), 32'd0);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    repeat (3) @(negedge clk);
    check("empty_play", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
